// File: rtl/race_arbiter_if.sv
// Bundle between the requesters/observer and the race arbiter.
// The slave modport is the arbiter's view, the master modport is the environment's view.
interface race_arbiter_if #(
    parameter int N     = 4,
    parameter int CNT_W = 8
);
    logic [N-1:0]     req;
    logic [N-1:0]     ack;
    logic [N-1:0]     grant;
    logic             busy;
    logic             obs_start;
    logic             obs_done;
    logic [CNT_W-1:0] race_cycles;
    logic             late;

    modport master (
        output req,
        output obs_done,
        input  ack,
        input  grant,
        input  busy,
        input  obs_start,
        input  race_cycles,
        input  late
    );

    modport slave (
        input  req,
        input  obs_done,
        output ack,
        output grant,
        output busy,
        output obs_start,
        output race_cycles,
        output late
    );
endinterface

// File: rtl/race_arbiter.sv
// Round-robin arbiter sharing one start/done race observer among N requesters,
// timing each race in cycles and returning the result with a one-hot ack.
module race_arbiter #(
    parameter int N       = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 200
) (
    input  logic           clk,
    input  logic           rst_l,
    race_arbiter_if.slave  bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        RELEASE = 2'd2,
        ACK     = 2'd3
    } state_t;

    state_t           state_reg, state_next;
    logic [PTR_W-1:0] ptr_reg, ptr_next;
    logic [PTR_W-1:0] win_reg, win_next;
    logic [N-1:0]     grant_reg, grant_next;
    logic [N-1:0]     ack_reg, ack_next;
    logic             obs_start_reg, obs_start_next;
    logic             busy_reg, busy_next;
    logic             late_reg, late_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] race_cycles_reg, race_cycles_next;

    logic [PTR_W-1:0] scan_idx;
    logic [PTR_W-1:0] cand_idx;
    logic             scan_hit;
    logic [N-1:0]     scan_onehot;

    // First asserted request at or after the round-robin pointer, wrapping.
    always_comb begin
        scan_idx = '0;
        cand_idx = '0;
        scan_hit = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand_idx = PTR_W'((int'(ptr_reg) + k) % N);
            if (!scan_hit && bus.req[cand_idx]) begin
                scan_hit = 1'b1;
                scan_idx = cand_idx;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign scan_onehot[gi] = (scan_idx == PTR_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next       = state_reg;
        ptr_next         = ptr_reg;
        win_next         = win_reg;
        grant_next       = grant_reg;
        ack_next         = ack_reg;
        obs_start_next   = obs_start_reg;
        busy_next        = busy_reg;
        late_next        = late_reg;
        cnt_next         = cnt_reg;
        race_cycles_next = race_cycles_reg;

        case (state_reg)
            IDLE: begin
                // obs_done is deliberately ignored here: a stale done must not start anything.
                if (|bus.req) begin
                    win_next       = scan_idx;
                    grant_next     = scan_onehot;
                    obs_start_next = 1'b1;
                    busy_next      = 1'b1;
                    cnt_next       = '0;
                    late_next      = 1'b0;
                    state_next     = START;
                end
            end
            START: begin
                if (cnt_reg != CNT_MAX) begin
                    cnt_next = cnt_reg + 1'b1;
                end
                if (cnt_reg >= TIMEOUT_C) begin
                    late_next = 1'b1;
                end
                if (bus.obs_done) begin
                    race_cycles_next = cnt_reg;
                    obs_start_next   = 1'b0;
                    state_next       = RELEASE;
                end
            end
            RELEASE: begin
                if (!bus.obs_done) begin
                    ack_next   = grant_reg;
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!bus.req[win_reg]) begin
                    ack_next   = '0;
                    grant_next = '0;
                    busy_next  = 1'b0;
                    ptr_next   = PTR_W'((int'(win_reg) + 1) % N);
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_reg       <= IDLE;
            ptr_reg         <= '0;
            win_reg         <= '0;
            grant_reg       <= '0;
            ack_reg         <= '0;
            obs_start_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            late_reg        <= 1'b0;
            cnt_reg         <= '0;
            race_cycles_reg <= '0;
        end else begin
            state_reg       <= state_next;
            ptr_reg         <= ptr_next;
            win_reg         <= win_next;
            grant_reg       <= grant_next;
            ack_reg         <= ack_next;
            obs_start_reg   <= obs_start_next;
            busy_reg        <= busy_next;
            late_reg        <= late_next;
            cnt_reg         <= cnt_next;
            race_cycles_reg <= race_cycles_next;
        end
    end

    assign bus.grant       = grant_reg;
    assign bus.ack         = ack_reg;
    assign bus.obs_start   = obs_start_reg;
    assign bus.busy        = busy_reg;
    assign bus.late        = late_reg;
    assign bus.race_cycles = race_cycles_reg;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (!rst_l) $onehot0(grant_reg));
    a_ack_onehot0:   assert property (@(posedge clk) disable iff (!rst_l) $onehot0(ack_reg));
    a_ack_in_grant:  assert property (@(posedge clk) disable iff (!rst_l) (ack_reg & ~grant_reg) == '0);
    a_start_busy:    assert property (@(posedge clk) disable iff (!rst_l) obs_start_reg |-> busy_reg);
endmodule

// File: tb/tb_race_arbiter.sv
// Randomized bench for race_arbiter: the bench plays requesters and observer and
// predicts winner, race length and late flag from the round-robin and timing rules.
module tb_race_arbiter;
    localparam int N       = 4;
    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 200;
    localparam int SAT     = (1 << CNT_W) - 1;

    logic clk;
    logic rst_l;
    int   n_vec;
    int   n_err;
    int   ptr_m;
    logic [N-1:0] req_v;

    race_arbiter_if #(.N(N), .CNT_W(CNT_W)) bus ();

    race_arbiter #(.N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .rst_l (rst_l),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Round-robin rule: first set request at or after the pointer, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int i = 0; i < N; i++) begin
            if (r[(p + i) % N]) return (p + i) % N;
        end
        return -1;
    endfunction

    // One full race; entered and left on a falling edge with the arbiter idle.
    task automatic do_race(input logic [N-1:0] req_set, input int k, input int done_hold,
                           input int ack_hold, input bit early_drop, input bit reraise);
        int w;
        int rc_exp;
        bit late_exp;
        logic [N-1:0] oh;
        req_v   = req_v | req_set;
        bus.req = req_v;
        w        = pick(req_v, ptr_m);
        oh       = N'(1) << w;
        rc_exp   = (k - 1 > SAT) ? SAT : k - 1;
        late_exp = (k - 1) >= TIMEOUT;

        @(negedge clk);
        chk("grant", 32'(bus.grant), 32'(oh));
        chk("obs_start_hi", 32'(bus.obs_start), 1);
        chk("busy_hi", 32'(bus.busy), 1);
        chk("late_clr", 32'(bus.late), 0);
        repeat (k - 1) @(negedge clk);
        chk("obs_start_kth", 32'(bus.obs_start), 1);
        bus.obs_done = 1'b1;

        @(negedge clk);
        chk("obs_start_lo", 32'(bus.obs_start), 0);
        chk("race_cycles", 32'(bus.race_cycles), 32'(rc_exp));
        repeat (done_hold) @(negedge clk);
        chk("ack_wait_done", 32'(bus.ack), 0);
        bus.obs_done = 1'b0;
        if (early_drop) begin
            req_v[w] = 1'b0;
            bus.req  = req_v;
        end

        @(negedge clk);
        chk("ack", 32'(bus.ack), 32'(oh));
        chk("ack_grant", 32'(bus.grant), 32'(oh));
        chk("ack_rc", 32'(bus.race_cycles), 32'(rc_exp));
        chk("late", 32'(bus.late), 32'(late_exp));
        if (!early_drop) begin
            repeat (ack_hold) @(negedge clk);
            chk("ack_hold", 32'(bus.ack), 32'(oh));
            req_v[w] = 1'b0;
            bus.req  = req_v;
        end

        @(negedge clk);
        chk("ack_drop", 32'(bus.ack), 0);
        chk("grant_drop", 32'(bus.grant), 0);
        chk("busy_drop", 32'(bus.busy), 0);
        ptr_m = (w + 1) % N;
        if (reraise) begin
            req_v[w] = 1'b1;
            bus.req  = req_v;
        end
        $display("race winner=%0d k=%0d race_cycles=%0d late=%0b early_drop=%0b req_now=%b",
                 w, k, rc_exp, late_exp, early_drop, req_v);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        ptr_m = 0;
        rst_l = 1'b0;
        req_v = '1;
        bus.req      = req_v;
        bus.obs_done = 1'b0;

        // Reset held with all requests pending.
        repeat (3) @(negedge clk);
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        chk("rst_obs_start", 32'(bus.obs_start), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_late", 32'(bus.late), 0);
        chk("rst_rc", 32'(bus.race_cycles), 0);
        rst_l = 1'b1;

        // Round robin with everyone re-requesting after each ack.
        for (int i = 0; i < 5; i++) begin
            do_race('1, 2 + i, i % 2, 1, 1'b0, 1'b1);
        end
        req_v = '0;
        bus.req = req_v;

        // Single race, done in the 5th start cycle.
        do_race(4'b0100, 5, 0, 2, 1'b0, 1'b0);

        // Late with saturation, then a short race clears late.
        do_race(4'b0001, 301, 0, 0, 1'b0, 1'b0);
        do_race(4'b0010, 5, 1, 0, 1'b0, 1'b0);
        do_race(4'b1000, TIMEOUT, 0, 0, 1'b0, 1'b0);
        do_race(4'b1000, TIMEOUT + 1, 0, 0, 1'b0, 1'b0);

        // Randomized traffic with lingering requests.
        for (int i = 0; i < 20; i++) begin
            int k;
            k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(190, 270))
                                            : int'($urandom_range(1, 12));
            do_race(N'($urandom_range(1, 15)), k, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
        end
        req_v = '0;
        bus.req = req_v;
        @(negedge clk);

        // Stale done while idle, then winner drops req as ack rises with req[3] waiting.
        do_race(4'b0001, 3, 0, 0, 1'b0, 1'b0);
        bus.obs_done = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stale_busy", 32'(bus.busy), 0);
            chk("stale_obs_start", 32'(bus.obs_start), 0);
        end
        bus.obs_done = 1'b0;
        @(negedge clk);
        do_race(4'b1010, 4, 0, 0, 1'b1, 1'b0);
        do_race(4'b0000, 2, 0, 0, 1'b0, 1'b0);

        // Reset in the middle of a race, pointer left non-zero beforehand.
        do_race(4'b0001, 2, 0, 0, 1'b0, 1'b0);
        req_v = 4'b0100;
        bus.req = req_v;
        @(negedge clk);
        chk("mid_grant", 32'(bus.grant), 32'b0100);
        repeat (2) @(negedge clk);
        rst_l = 1'b0;
        #1;
        chk("mid_rst_obs_start", 32'(bus.obs_start), 0);
        chk("mid_rst_grant", 32'(bus.grant), 0);
        chk("mid_rst_busy", 32'(bus.busy), 0);
        req_v = '0;
        bus.req = req_v;
        @(negedge clk);
        rst_l = 1'b1;
        ptr_m = 0;
        do_race('1, 3, 0, 0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
